// File: rtl/calculator_seq_div.sv
`default_nettype none
// ============================================================================
//  Module   : calculator_pkg / calculator_seq_div
//  Purpose  : Signed accumulator calculator with add, subtract, multiply,
//             clear and an iterative restoring signed divide. Optional
//             saturation plus overflow / divide-by-zero status, and a
//             busy/done handshake toward the display side.
//  Ports    : clk          system clock
//             reset_n      asynchronous active-low reset
//             start        single-cycle request pulse (sampled in IDLE only)
//             buttons[4:0] one-hot op select (positions in calculator_pkg)
//             switch       signed operand, sign-extended to BITS
//             accum        accumulator value
//             busy         high while an operation is in progress
//             done         one-cycle pulse when a result is written
//             overflow     status of the last completed operation
//             div_by_zero  status of the last completed operation
//  Revision : 1.0  initial release
// ============================================================================

package calculator_pkg;
  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_CENTER = 4;
endpackage

module calculator_seq_div
  import calculator_pkg::*;
#(
  parameter int BITS     = 32,
  parameter int SW_BITS  = 16,
  parameter int SATURATE = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [4:0]         buttons,
  input  logic [SW_BITS-1:0] switch,
  output logic [BITS-1:0]    accum,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic               div_by_zero
);

  localparam int CNT_W = $clog2(BITS);
  localparam logic [BITS-1:0] ONE     = {{(BITS-1){1'b0}}, 1'b1};
  localparam logic [BITS-1:0] ZERO    = '0;
  localparam logic [BITS-1:0] MAX_POS = {1'b0, {(BITS-1){1'b1}}};
  localparam logic [BITS-1:0] MIN_NEG = {1'b1, {(BITS-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_MUL  = 3'd1,
    OP_CLR  = 3'd2,
    OP_ADD  = 3'd3,
    OP_SUB  = 3'd4,
    OP_DIV  = 3'd5
  } op_t;

  // Registered state and its next values
  state_t            state, state_n;
  op_t               op, op_n;
  logic [BITS-1:0]   operand, operand_n;
  logic [BITS-1:0]   accum_n;
  logic              overflow_n, div_by_zero_n, done_n;
  logic [BITS-1:0]   rem, rem_n;        // partial remainder
  logic [BITS-1:0]   quo, quo_n;        // dividend shifting out, quotient shifting in
  logic [BITS-1:0]   dvsr, dvsr_n;      // divisor magnitude
  logic [CNT_W-1:0]  count, count_n;
  logic              quo_neg, quo_neg_n;

  // Priority decode: UP > DOWN > LEFT > RIGHT > CENTER
  function automatic op_t decode(input logic [4:0] b);
    if (b[BTN_UP])          return OP_MUL;
    else if (b[BTN_DOWN])   return OP_CLR;
    else if (b[BTN_LEFT])   return OP_ADD;
    else if (b[BTN_RIGHT])  return OP_SUB;
    else if (b[BTN_CENTER]) return OP_DIV;
    else                    return OP_NONE;
  endfunction

  // Magnitude as unsigned; the most negative value maps to 2^(BITS-1), which
  // still fits in BITS unsigned bits.
  function automatic logic [BITS-1:0] magnitude(input logic [BITS-1:0] v);
    return v[BITS-1] ? (~v + ONE) : v;
  endfunction

  // Arithmetic kept one bit wider than the accumulator so overflow is the
  // disagreement between the two top bits.
  logic [BITS:0]     sum_add, sum_sub;
  logic [2*BITS-1:0] prod;
  logic              add_ovf, sub_ovf, mul_ovf;

  assign sum_add = {accum[BITS-1], accum} + {operand[BITS-1], operand};
  assign sum_sub = {accum[BITS-1], accum} - {operand[BITS-1], operand};
  assign prod    = $signed({{BITS{accum[BITS-1]}}, accum})
                 * $signed({{BITS{operand[BITS-1]}}, operand});

  assign add_ovf = sum_add[BITS] ^ sum_add[BITS-1];
  assign sub_ovf = sum_sub[BITS] ^ sum_sub[BITS-1];
  // Product fits only if its upper BITS+1 bits are all copies of the sign.
  assign mul_ovf = prod[2*BITS-1:BITS-1] != {(BITS+1){prod[2*BITS-1]}};

  // Restoring divide step: bring down the next dividend bit and subtract the
  // divisor if it fits. The difference is taken at BITS width because when
  // trial >= dvsr the result is always below 2^BITS.
  logic [BITS:0]   trial;
  logic [BITS-1:0] trial_diff;
  logic            trial_fits;

  assign trial      = {rem, quo[BITS-1]};
  assign trial_diff = trial[BITS-1:0] - dvsr;
  assign trial_fits = trial >= {1'b0, dvsr};

  // A non-negative quotient with its top bit set can only be
  // -2^(BITS-1) / -1, which is unrepresentable.
  logic fix_ovf;
  assign fix_ovf = !quo_neg && quo[BITS-1];

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      op          <= OP_NONE;
      operand     <= '0;
      accum       <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
      rem         <= '0;
      quo         <= '0;
      dvsr        <= '0;
      count       <= '0;
      quo_neg     <= 1'b0;
    end else begin
      state       <= state_n;
      op          <= op_n;
      operand     <= operand_n;
      accum       <= accum_n;
      overflow    <= overflow_n;
      div_by_zero <= div_by_zero_n;
      done        <= done_n;
      rem         <= rem_n;
      quo         <= quo_n;
      dvsr        <= dvsr_n;
      count       <= count_n;
      quo_neg     <= quo_neg_n;
    end
  end

  always_comb begin
    state_n       = state;
    op_n          = op;
    operand_n     = operand;
    accum_n       = accum;
    overflow_n    = overflow;
    div_by_zero_n = div_by_zero;
    done_n        = 1'b0;
    rem_n         = rem;
    quo_n         = quo;
    dvsr_n        = dvsr;
    count_n       = count;
    quo_neg_n     = quo_neg;

    case (state)
      IDLE: begin
        if (start) begin
          op_n      = decode(buttons);
          operand_n = BITS'($signed(switch));
          state_n   = EXEC;
        end
      end

      EXEC: begin
        state_n = IDLE;
        case (op)
          OP_MUL: begin
            if (mul_ovf && (SATURATE != 0))
              accum_n = prod[2*BITS-1] ? MIN_NEG : MAX_POS;
            else
              accum_n = prod[BITS-1:0];
            overflow_n    = mul_ovf;
            div_by_zero_n = 1'b0;
            done_n        = 1'b1;
          end
          OP_CLR: begin
            accum_n       = ZERO;
            overflow_n    = 1'b0;
            div_by_zero_n = 1'b0;
            done_n        = 1'b1;
          end
          OP_ADD: begin
            if (add_ovf && (SATURATE != 0))
              accum_n = sum_add[BITS] ? MIN_NEG : MAX_POS;
            else
              accum_n = sum_add[BITS-1:0];
            overflow_n    = add_ovf;
            div_by_zero_n = 1'b0;
            done_n        = 1'b1;
          end
          OP_SUB: begin
            if (sub_ovf && (SATURATE != 0))
              accum_n = sum_sub[BITS] ? MIN_NEG : MAX_POS;
            else
              accum_n = sum_sub[BITS-1:0];
            overflow_n    = sub_ovf;
            div_by_zero_n = 1'b0;
            done_n        = 1'b1;
          end
          OP_DIV: begin
            if (operand == ZERO) begin
              // Accumulator is left untouched.
              overflow_n    = 1'b0;
              div_by_zero_n = 1'b1;
              done_n        = 1'b1;
            end else begin
              quo_n     = magnitude(accum);
              rem_n     = ZERO;
              dvsr_n    = magnitude(operand);
              count_n   = '0;
              quo_neg_n = accum[BITS-1] ^ operand[BITS-1];
              state_n   = DIV;
            end
          end
          default: ;  // no button: back to IDLE without a done pulse
        endcase
      end

      DIV: begin
        if (trial_fits) begin
          rem_n = trial_diff;
          quo_n = {quo[BITS-2:0], 1'b1};
        end else begin
          rem_n = trial[BITS-1:0];
          quo_n = {quo[BITS-2:0], 1'b0};
        end
        count_n = count + CNT_W'(1);
        if (count == CNT_W'(BITS - 1))
          state_n = FIX;
      end

      FIX: begin
        if (fix_ovf)
          accum_n = (SATURATE != 0) ? MAX_POS : quo;
        else
          accum_n = quo_neg ? (~quo + ONE) : quo;
        overflow_n    = fix_ovf;
        div_by_zero_n = 1'b0;
        done_n        = 1'b1;
        state_n       = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_calculator_seq_div.sv
`default_nettype none
// ============================================================================
//  Module   : tb_calculator_seq_div
//  Purpose  : Self-checking bench for calculator_seq_div. Drives a wrapping
//             (SATURATE=0) and a saturating (SATURATE=1) instance with the
//             same stimulus; expected results come from a wide-integer model
//             and are queued per instance, then popped on each done pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_calculator_seq_div;
  import calculator_pkg::*;

  localparam int BITS    = 32;
  localparam int SW_BITS = 16;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -MAXV - 64'sd1;

  localparam logic [4:0] B_UP     = 5'b1 << BTN_UP;
  localparam logic [4:0] B_DOWN   = 5'b1 << BTN_DOWN;
  localparam logic [4:0] B_LEFT   = 5'b1 << BTN_LEFT;
  localparam logic [4:0] B_RIGHT  = 5'b1 << BTN_RIGHT;
  localparam logic [4:0] B_CENTER = 5'b1 << BTN_CENTER;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start;
  logic [4:0]         buttons;
  logic [SW_BITS-1:0] switch;

  logic [BITS-1:0] accum_w, accum_s;
  logic            busy_w, busy_s, done_w, done_s;
  logic            ovf_w, ovf_s, dz_w, dz_s;

  always #5 clk = ~clk;

  calculator_seq_div #(.BITS(BITS), .SW_BITS(SW_BITS), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .start(start), .buttons(buttons), .switch(switch),
    .accum(accum_w), .busy(busy_w), .done(done_w), .overflow(ovf_w), .div_by_zero(dz_w)
  );

  calculator_seq_div #(.BITS(BITS), .SW_BITS(SW_BITS), .SATURATE(1)) dut_sat (
    .clk(clk), .reset_n(reset_n), .start(start), .buttons(buttons), .switch(switch),
    .accum(accum_s), .busy(busy_s), .done(done_s), .overflow(ovf_s), .div_by_zero(dz_s)
  );

  typedef struct {
    logic [31:0] acc;
    logic        ovf;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t q_w[$];
  exp_t q_s[$];

  int checks = 0;
  int errors = 0;

  // Model state per instance
  logic [31:0] m_acc_w = '0, m_acc_s = '0;
  logic        m_ovf_w = 1'b0, m_ovf_s = 1'b0, m_dz_w = 1'b0, m_dz_s = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // 0 none, 1 mul, 2 clear, 3 add, 4 sub, 5 div
  function automatic int dec(input logic [4:0] b);
    if (b[BTN_UP])     return 1;
    if (b[BTN_DOWN])   return 2;
    if (b[BTN_LEFT])   return 3;
    if (b[BTN_RIGHT])  return 4;
    if (b[BTN_CENTER]) return 5;
    return 0;
  endfunction

  function automatic exp_t model(input logic [31:0] acc, input logic povf, input logic pdz,
                                 input int op, input logic [15:0] sw, input bit sat);
    exp_t   e;
    longint a, b, r;
    a = longint'($signed(acc));
    b = longint'($signed(sw));
    r = 0;
    e.acc = acc; e.ovf = povf; e.dz = pdz; e.lat = 1;
    case (op)
      1: r = a * b;
      2: r = 0;
      3: r = a + b;
      4: r = a - b;
      5: begin
        if (b == 0) begin
          e.dz = 1'b1; e.ovf = 1'b0;
          return e;
        end
        r = a / b;
        e.lat = BITS + 2;
      end
      default: return e;
    endcase
    e.dz  = 1'b0;
    e.ovf = (r > MAXV) || (r < MINV);
    if (e.ovf && sat) e.acc = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    else              e.acc = r[31:0];
    return e;
  endfunction

  // Issue one operation, wait (bounded) for done, and score both instances.
  task automatic do_op(input string tag, input logic [4:0] btn, input logic [15:0] sw,
                       input bit second_start);
    exp_t ew, es;
    int   op, cyc, busy_cyc;
    bit   got, sat_done_ok;
    op = dec(btn);
    ew = model(m_acc_w, m_ovf_w, m_dz_w, op, sw, 1'b0);
    es = model(m_acc_s, m_ovf_s, m_dz_s, op, sw, 1'b1);
    q_w.push_back(ew);
    q_s.push_back(es);
    m_acc_w = ew.acc; m_ovf_w = ew.ovf; m_dz_w = ew.dz;
    m_acc_s = es.acc; m_ovf_s = es.ovf; m_dz_s = es.dz;

    start = 1'b1; buttons = btn; switch = sw;
    @(posedge clk); #1;
    start = 1'b0;
    buttons = 5'($urandom);
    switch  = 16'($urandom);
    cyc = 0; busy_cyc = 0; got = 1'b0; sat_done_ok = 1'b0;
    while (!got && cyc < 64) begin
      if (busy_w) busy_cyc++;
      if (second_start && cyc == 4) begin
        start = 1'b1; buttons = B_LEFT; switch = 16'h0100;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (done_w) begin
        got = 1'b1;
        sat_done_ok = done_s;
      end
    end
    start = 1'b0;
    chk({tag, " done seen"}, 32'(got), 32'd1);
    ew = q_w.pop_front();
    es = q_s.pop_front();
    if (got) begin
      chk({tag, " latency"},      32'(cyc),      32'(ew.lat));
      chk({tag, " busy cycles"},  32'(busy_cyc), 32'(ew.lat));
      chk({tag, " done sat"},     32'(sat_done_ok), 32'd1);
      chk({tag, " accum wrap"},   accum_w,       ew.acc);
      chk({tag, " ovf wrap"},     32'(ovf_w),    32'(ew.ovf));
      chk({tag, " dz wrap"},      32'(dz_w),     32'(ew.dz));
      chk({tag, " accum sat"},    accum_s,       es.acc);
      chk({tag, " ovf sat"},      32'(ovf_s),    32'(es.ovf));
      chk({tag, " dz sat"},       32'(dz_s),     32'(es.dz));
    end
    if (second_start) begin
      @(posedge clk); #1;
      chk({tag, " no 2nd done"}, 32'(done_w), 32'd0);
      chk({tag, " idle after"},  32'(busy_w), 32'd0);
      chk({tag, " accum held"},  accum_w,     ew.acc);
    end
  endtask

  initial begin
    bit seen;

    reset_n = 1'b0; start = 1'b0; buttons = '0; switch = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset accum wrap", accum_w, 32'h0);
    chk("reset accum sat",  accum_s, 32'h0);
    chk("reset busy",       32'(busy_w), 32'd0);
    chk("reset done",       32'(done_w), 32'd0);
    chk("reset ovf",        32'(ovf_w),  32'd0);
    chk("reset dz",         32'(dz_w),   32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Add / subtract / multiply
    do_op("add100",  B_LEFT,  16'd100,  1'b0);
    do_op("sub250",  B_RIGHT, 16'd250,  1'b0);
    do_op("mul1000", B_UP,    16'd1000, 1'b0);

    // Build 0x40000000, then multiply by 4 -> overflow
    do_op("clr a",   B_DOWN, 16'd0,    1'b0);
    do_op("b1",      B_LEFT, 16'h4000, 1'b0);
    do_op("b2",      B_UP,   16'h4000, 1'b0);
    do_op("b3",      B_UP,   16'd4,    1'b0);
    do_op("mul ovf", B_UP,   16'd4,    1'b0);

    // Build 0x7FFFFFF0, then add 0x20 -> overflow
    do_op("clr b",   B_DOWN,  16'd0,    1'b0);
    do_op("c1",      B_LEFT,  16'h2000, 1'b0);
    do_op("c2",      B_UP,    16'h4000, 1'b0);
    do_op("c3",      B_RIGHT, 16'd1,    1'b0);
    do_op("c4",      B_UP,    16'd16,   1'b0);
    do_op("add ovf", B_LEFT,  16'h0020, 1'b0);

    // Button priority with several bits set
    do_op("clr c",   B_DOWN, 16'd0, 1'b0);
    do_op("prio add", B_LEFT | B_RIGHT | B_CENTER, 16'd5, 1'b0);
    do_op("prio mul", B_UP | B_DOWN, 16'd3, 1'b0);

    // No button: one busy cycle, no done, accumulator untouched
    start = 1'b1; buttons = 5'b0; switch = 16'd77;
    @(posedge clk); #1;
    start = 1'b0;
    chk("noop busy", 32'(busy_w), 32'd1);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen |= done_w;
    end
    chk("noop no done", 32'(seen),   32'd0);
    chk("noop idle",    32'(busy_w), 32'd0);
    chk("noop accum",   accum_w,     m_acc_w);

    // Divide -1000 / 7 with an ignored start mid-divide
    do_op("clr d",   B_DOWN,   16'd0,    1'b0);
    do_op("d1",      B_RIGHT,  16'd1000, 1'b0);
    do_op("div7",    B_CENTER, 16'd7,    1'b1);
    do_op("div neg", B_CENTER, 16'hFFFD, 1'b0);

    // Divide by zero, then a following add clears the flag
    do_op("clr e",   B_DOWN,   16'd0,  1'b0);
    do_op("e1",      B_LEFT,   16'd55, 1'b0);
    do_op("div0",    B_CENTER, 16'd0,  1'b0);
    do_op("after0",  B_LEFT,   16'd1,  1'b0);

    // -2^31 / -1
    do_op("clr f",   B_DOWN,   16'd0,    1'b0);
    do_op("f1",      B_LEFT,   16'hC000, 1'b0);
    do_op("f2",      B_UP,     16'h4000, 1'b0);
    do_op("f3",      B_UP,     16'd8,    1'b0);
    do_op("div ovf", B_CENTER, 16'hFFFF, 1'b0);

    // Reset in the middle of a divide
    start = 1'b1; buttons = B_CENTER; switch = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst mid accum wrap", accum_w, 32'h0);
    chk("rst mid accum sat",  accum_s, 32'h0);
    chk("rst mid busy",       32'(busy_w), 32'd0);
    seen = done_w;
    repeat (2) begin
      @(posedge clk); #1;
      seen |= done_w;
    end
    reset_n = 1'b1;
    m_acc_w = '0; m_ovf_w = 1'b0; m_dz_w = 1'b0;
    m_acc_s = '0; m_ovf_s = 1'b0; m_dz_s = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= done_w;
    end
    chk("rst mid no done", 32'(seen), 32'd0);
    do_op("clr post", B_DOWN, 16'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/calculator_seq_div.md
Name: calculator_seq_div

Overview:
- Parametrised successor of the switch/button accumulator calculator.
- Signed accumulator of BITS width with add, subtract, multiply, clear, and a new iterative signed divide.
- Adds optional saturation, overflow and divide-by-zero status, and a busy/done handshake toward the display/top level.
- Sits between the button debouncer/edge detector and the seven-segment display driver.

Parameters:
- BITS, 32: accumulator width (two's complement); minimum 8.
- SW_BITS, 16: operand width from the switches; SW_BITS <= BITS.
- SATURATE, 0: 0 means wrap on overflow; 1 means clamp to the signed max/min of BITS.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request pulse; operation on buttons, operand on switch
- buttons  in  5  one-hot operation select; bit positions from calculator_pkg (UP, DOWN, LEFT, RIGHT, CENTER)
- switch  in  SW_BITS  signed operand
- accum  out  BITS  accumulator value
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when the result is written
- overflow  out  1  status of the last completed operation
- div_by_zero  out  1  status of the last completed operation

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset_n low, asynchronous, any state):
  - state=IDLE; accum=0, busy=0, done=0, overflow=0, div_by_zero=0.
  - An in-flight divide is abandoned.
- Operation map: UP=multiply, DOWN=clear, LEFT=add, RIGHT=subtract, CENTER=divide.
  - Multiple bits set: priority UP>DOWN>LEFT>RIGHT>CENTER.
  - No bit set: no operation; return to IDLE with no done pulse.
- Operand: switch is sign-extended to BITS.
- States:
  - IDLE: busy=0. When start=1, capture op and operand, go to EXEC. start outside IDLE is ignored.
  - EXEC: add/sub/mul/clear write accum, pulse done, return to IDLE. Divide by zero is handled here (see Divide). Otherwise load the divider with magnitudes and go to DIV.
  - DIV: restoring divide, one quotient bit per cycle for exactly BITS cycles, then go to FIX.
  - FIX: apply the sign, write accum, pulse done, go to IDLE.
- Latency:
  - Start sampled at edge N; non-divide result visible after edge N+1, with done high for that cycle.
  - Divide result after edge N+BITS+2.
  - busy = (state != IDLE).
- Add/sub: computed at BITS+1 width; overflow when the result falls outside the signed range.
- Multiply: full 2*BITS product; overflow when the product does not fit the signed BITS range.
- Overflow handling:
  - SATURATE=0: result truncated to the low BITS (wrap).
  - SATURATE=1: clamp to 2^(BITS-1)-1 or -2^(BITS-1).
- Divide:
  - accum / operand, quotient truncated toward zero, remainder discarded.
  - Operand 0: accum unchanged, div_by_zero=1, overflow=0, done in EXEC (latency 1).
  - accum = -2^(BITS-1) with operand -1: overflow=1. Result is -2^(BITS-1) when SATURATE=0, 2^(BITS-1)-1 when SATURATE=1.
- Clear: accum=0, overflow=0, div_by_zero=0.
- Status flags: overflow and div_by_zero update only on the done cycle and hold until the next completed operation. They are not sticky across operations.
- Switch changes after the start cycle do not affect the operation in progress.

Test Plan:
- BITS=32, SW_BITS=16, SATURATE=0. Reset, start LEFT with switch=100 -> accum=100 one cycle after start, done pulse, flags 0. Then RIGHT with switch=250 -> accum=0xFFFFFF6A (-150).
- accum=-150, UP with switch=1000 -> accum=-150000 (0xFFFDB610), overflow=0.
- accum=0x40000000, UP with switch=4:
  - SATURATE=0 -> accum=0x00000000, overflow=1.
  - SATURATE=1 -> accum=0x7FFFFFFF.
- accum=0x7FFFFFF0, LEFT with switch=0x0020:
  - SATURATE=0 -> accum=0x80000010, overflow=1.
  - SATURATE=1 -> accum=0x7FFFFFFF.
- accum=-1000, CENTER with switch=7 -> busy high 34 cycles, accum=-142 (0xFFFFFF72) after edge N+34. A second start pulse at N+5 is ignored.
- Divide corner cases:
  - accum=55, CENTER with switch=0 -> accum=55, div_by_zero=1, done after one cycle.
  - accum=0x80000000, switch=-1 -> overflow=1.
- Reset mid-operation: start CENTER, drive reset_n low at cycle 10 -> accum=0, busy=0, done never pulses. After release, DOWN -> accum=0 with done pulse.
